// File: rtl/qq_pkg.sv
// Shared types for the quick_queue_param priority queue: the cell entry
// record at default widths and the per-cycle operation code.
package qq_pkg;

  localparam int unsigned QQ_KEY_W  = 32;
  localparam int unsigned QQ_DATA_W = 32;

  // Operation applied to the whole cell array in one cycle.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } op_e;

  // One stored entry; invalid entries are kept all-zero.
  typedef struct packed {
    logic                 valid;
    logic [QQ_KEY_W-1:0]  key;
    logic [QQ_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/qq_cell.sv
// One storage cell of the shift-array priority queue. The top decides where
// the new entry lands; the cell only picks between hold, new, left and right.
module qq_cell
  import qq_pkg::*;
#(
  parameter type ent_t = entry_t
) (
  input  logic clk,
  input  logic rst,
  input  op_e  i_op,
  input  ent_t i_left,
  input  ent_t i_right,
  input  ent_t i_new,
  input  logic i_ins_here,
  input  logic i_shift,
  output ent_t o_ent
);

  ent_t r_ent;

  // Next entry: enq shifts up (take left), deq and replace shift down (take right).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent <= '0;
    end else begin
      case (i_op)
        OP_DEQ: r_ent <= i_right;
        OP_ENQ: begin
          if (i_ins_here) r_ent <= i_new;
          else if (i_shift) r_ent <= i_left;
        end
        OP_REPL: begin
          if (i_ins_here) r_ent <= i_new;
          else if (i_shift) r_ent <= i_right;
        end
        default: ;
      endcase
    end
  end

  assign o_ent = r_ent;

endmodule

// File: rtl/quick_queue_param.sv
// Parametrised shift-array priority queue (min-key first, FIFO among equal
// keys). Optional sticky overflow/underflow flags are built when the macro
// QQ_ERR_FLAGS_EN is defined.
module quick_queue_param
  import qq_pkg::*;
#(
  parameter int unsigned KEY_W  = QQ_KEY_W,
  parameter int unsigned DATA_W = QQ_DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq,
  input  logic              deq,
  input  logic [7:0]        array_size,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [KEY_W-1:0]  key_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
`ifdef QQ_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  typedef struct packed {
    logic              valid;
    logic [KEY_W-1:0]  key;
    logic [DATA_W-1:0] data;
  } cell_t;

  cell_t            w_cell [DEPTH];
  cell_t            w_new;
  op_e              w_op;
  logic [31:0]      w_cap;
  logic             w_at_cap;
  logic [DEPTH-1:0] w_gt;
  logic [CNT_W-1:0] w_pos;
  logic [CNT_W-1:0] w_ins_pos;
  logic [DEPTH-1:0] w_ins_here;
  logic [DEPTH-1:0] w_shift;
  logic [CNT_W-1:0] w_count_d;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  assign w_new = '{valid: 1'b1, key: key_i, data: data_i};

  // Effective capacity min(array_size, DEPTH); compared live so a runtime
  // lowering of array_size blocks inserts immediately.
  assign w_cap    = (32'(array_size) >= DEPTH) ? DEPTH : 32'(array_size);
  assign w_at_cap = 32'(r_count) >= w_cap;

  // Op decode: deq on empty is ignored, plain enq at capacity is dropped.
  always_comb begin
    w_op = OP_NONE;
    if (deq && !r_empty) begin
      w_op = enq ? OP_REPL : OP_DEQ;
    end else if (enq && !w_at_cap) begin
      w_op = OP_ENQ;
    end
  end

  // Parallel compare; on replace the outgoing head takes no part.
  always_comb begin
    w_gt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_gt[i] = w_cell[i].valid && (w_cell[i].key > key_i) && !(i == 0 && w_op == OP_REPL);
    end
  end

  // First strictly-greater cell, or the end of the list when none.
  always_comb begin
    w_pos = r_count;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (w_gt[i]) w_pos = CNT_W'(i);
    end
  end

  // Replace lands one slot lower because everything below shifts toward the head.
  always_comb begin
    w_ins_pos = (w_op == OP_REPL) ? (w_pos - CNT_W'(1)) : w_pos;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_ins_here[i] = (w_ins_pos == CNT_W'(i));
      w_shift[i]    = (w_op == OP_REPL) ? (CNT_W'(i) < w_ins_pos) : (CNT_W'(i) > w_ins_pos);
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_cell
    cell_t w_left;
    cell_t w_right;

    if (g == 0) begin : g_head
      assign w_left = '0;
    end else begin : g_body
      assign w_left = w_cell[g-1];
    end

    if (g == int'(DEPTH) - 1) begin : g_top
      assign w_right = '0;
    end else begin : g_below
      assign w_right = w_cell[g+1];
    end

    qq_cell #(
      .ent_t (cell_t)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .i_op       (w_op),
      .i_left     (w_left),
      .i_right    (w_right),
      .i_new      (w_new),
      .i_ins_here (w_ins_here[g]),
      .i_shift    (w_shift[g]),
      .o_ent      (w_cell[g])
    );
  end

  // Next occupancy; replace keeps the count.
  always_comb begin
    case (w_op)
      OP_ENQ:  w_count_d = r_count + CNT_W'(1);
      OP_DEQ:  w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Count and status flags registered together with the cells.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= (w_cap == 32'd0);
    end else begin
      r_count <= w_count_d;
      r_empty <= (w_count_d == '0);
      r_full  <= (32'(w_count_d) >= w_cap);
    end
  end

  assign key_o   = w_cell[0].key;
  assign data_o  = w_cell[0].data;
  assign valid_o = w_cell[0].valid;
  assign empty   = r_empty;
  assign full    = r_full;
  assign count   = r_count;

`ifdef QQ_ERR_FLAGS_EN
  logic w_drop;
  logic w_ignore;
  logic r_overflow;
  logic r_underflow;

  assign w_drop   = enq && !(deq && !r_empty) && w_at_cap;
  assign w_ignore = deq && r_empty;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_drop)   r_overflow  <= 1'b1;
      if (w_ignore) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
